clock_time_ctrl: RTL and testbench

// - Controller and sequencer for the 24-hour timekeeping datapath.
// - Divides the system clock into a 1 Hz tick and advances hh:mm:ss with carries.
// - Runs a user set-mode FSM driven by two buttons: MODE and INC.
// - Sits between the board button synchronisers and the display driver; the only owner of the time registers.
//

---
 rtl/clock_time_ctrl_pkg.sv | 35 +++
 rtl/clock_time_ctrl_if.sv | 24 ++
 rtl/clock_time_ctrl_tick_prescaler.sv | 39 +++
 rtl/clock_time_ctrl.sv | 131 +++++++++++++
 tb/tb_clock_time_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_time_ctrl_pkg.sv
// Shared types, field widths and wrap helpers for the 24-hour timekeeping controller.
package clock_pkg;

    localparam int unsigned HR_W    = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned FIELD_W = 2;

    localparam logic [HR_W-1:0]  MAX_HR  = HR_W'(23);
    localparam logic [MIN_W-1:0] MAX_MIN = MIN_W'(59);
    localparam logic [SEC_W-1:0] MAX_SEC = SEC_W'(59);

    // Encoding is exported unchanged as set_field.
    typedef enum logic [FIELD_W-1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_e;

    typedef struct packed {
        logic [HR_W-1:0]  hh;
        logic [MIN_W-1:0] mm;
        logic [SEC_W-1:0] ss;
    } hms_t;

    function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] v);
        return (v == MAX_HR) ? '0 : v + HR_W'(1);
    endfunction

    // Minutes and seconds share width and limit.
    function automatic logic [MIN_W-1:0] inc_60(input logic [MIN_W-1:0] v);
        return (v == MAX_MIN) ? '0 : v + MIN_W'(1);
    endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Button inputs and time/display outputs of the timekeeping controller.
interface clock_time_ctrl_if;
    import clock_pkg::*;

    logic                   mode_btn;
    logic                   inc_btn;
    logic [HR_W-1:0]        hours;
    logic [MIN_W-1:0]       minutes;
    logic [SEC_W-1:0]       seconds;
    logic [FIELD_W-1:0]     set_field;
    logic                   sec_tick;
    logic                   day_wrap;

    modport master (
        output mode_btn, inc_btn,
        input  hours, minutes, seconds, set_field, sec_tick, day_wrap
    );

    modport slave (
        input  mode_btn, inc_btn,
        output hours, minutes, seconds, set_field, sec_tick, day_wrap
    );

endinterface

// File: rtl/clock_time_ctrl_tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ cycles.
module tick_prescaler #(
    parameter int unsigned CLK_HZ  = 5000,
    parameter int unsigned PRESC_W = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESC_W-1:0] TERM = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] count_q;
    logic [PRESC_W-1:0] count_d;

    // Tick still fires on a clear cycle; clear only affects the next count.
    always_comb begin
        tick    = en & (count_q == TERM);
        count_d = count_q;
        if (clr || !en) begin
            count_d = '0;
        end else if (count_q == TERM) begin
            count_d = '0;
        end else begin
            count_d = count_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: button edge detect, RUN/SET_HR/SET_MIN sequencer and hh:mm:ss counters.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 5000,
    parameter int unsigned PRESC_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    clock_time_ctrl_if.slave  bus
);

    state_e state_q, state_d;
    hms_t   time_q,  time_d;
    logic   sec_tick_q,  sec_tick_d;
    logic   day_wrap_q,  day_wrap_d;
    logic   mode_prev_q, mode_prev_d;
    logic   inc_prev_q,  inc_prev_d;

    logic   mode_press;
    logic   inc_press;
    logic   tick;
    logic   presc_en;
    logic   presc_clr;

    // Rising-edge detect against the previous level.
    always_comb begin
        mode_prev_d = bus.mode_btn;
        inc_prev_d  = bus.inc_btn;
        mode_press  = bus.mode_btn & ~mode_prev_q;
        inc_press   = bus.inc_btn  & ~inc_prev_q;
    end

    // Counting only in RUN; cleared on leaving RUN so SET states see a zero count.
    always_comb begin
        presc_en  = (state_q == RUN);
        presc_clr = (state_q != RUN) | mode_press;
    end

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    // Next-state and time update; MODE takes priority over INC in SET states.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;

        case (state_q)
            RUN: begin
                if (tick) begin
                    sec_tick_d = 1'b1;
                    if (time_q.ss == MAX_SEC) begin
                        time_d.ss = '0;
                        if (time_q.mm == MAX_MIN) begin
                            time_d.mm  = '0;
                            time_d.hh  = inc_hr(time_q.hh);
                            day_wrap_d = (time_q.hh == MAX_HR);
                        end else begin
                            time_d.mm = inc_60(time_q.mm);
                        end
                    end else begin
                        time_d.ss = inc_60(time_q.ss);
                    end
                end
                if (mode_press) begin
                    state_d = SET_HR;
                end
            end

            SET_HR: begin
                if (mode_press) begin
                    state_d = SET_MIN;
                end else if (inc_press) begin
                    time_d.hh = inc_hr(time_q.hh);
                end
            end

            SET_MIN: begin
                if (mode_press) begin
                    state_d   = RUN;
                    time_d.ss = '0;
                end else if (inc_press) begin
                    time_d.mm = inc_60(time_q.mm);
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Button history resets high so a button held through reset is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            time_q      <= '0;
            sec_tick_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            sec_tick_q  <= sec_tick_d;
            day_wrap_q  <= day_wrap_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
        end
    end

    always_comb begin
        bus.hours     = time_q.hh;
        bus.minutes   = time_q.mm;
        bus.seconds   = time_q.ss;
        bus.set_field = state_q;
        bus.sec_tick  = sec_tick_q;
        bus.day_wrap  = day_wrap_q;
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: seconds-of-day reference model, vector table and directed corner sequences.
module tb_clock_time_ctrl;

    localparam int HZ  = 4;
    localparam int DAY = 86400;

    logic clk = 1'b0;
    logic rst = 1'b0;

    clock_time_ctrl_if bus ();

    clock_time_ctrl #(
        .CLK_HZ  (HZ),
        .PRESC_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: time as seconds since midnight, mode 0/1/2, prescaler phase.
    int m_t, m_st, m_ph;
    bit m_mprev, m_iprev, m_tick, m_wrap;

    typedef struct {
        bit mode;
        bit inc;
        int hh;
        int mm;
        int ss;
        int field;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [20:0] pack(input int h, input int m, input int s,
                                         input int f, input bit tk, input bit wr);
        return {5'(h), 6'(m), 6'(s), 2'(f), tk, wr};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {bus.hours, bus.minutes, bus.seconds, bus.set_field, bus.sec_tick, bus.day_wrap};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_st = 0; m_ph = 0;
        m_mprev = 1'b1; m_iprev = 1'b1;
        m_tick = 1'b0; m_wrap = 1'b0;
    endtask

    task automatic model_edge();
        bit mp, ip, tk;
        mp = bus.mode_btn && !m_mprev;
        ip = bus.inc_btn && !m_iprev;
        m_mprev = bus.mode_btn;
        m_iprev = bus.inc_btn;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        case (m_st)
            0: begin
                tk = (m_ph == HZ - 1);
                m_ph = tk ? 0 : m_ph + 1;
                if (tk) begin
                    m_t = (m_t + 1) % DAY;
                    m_tick = 1'b1;
                    m_wrap = (m_t == 0);
                end
                if (mp) begin m_st = 1; m_ph = 0; end
            end
            1: begin
                if (mp) m_st = 2;
                else if (ip) m_t = (m_t + 3600) % DAY;
            end
            default: begin
                if (mp) begin
                    m_st = 0;
                    m_t = m_t - m_t % 60;
                    m_ph = 0;
                end else if (ip) begin
                    m_t = m_t - (m_t % 3600) + (((m_t / 60) % 60 + 1) % 60) * 60 + m_t % 60;
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", int'(dut_vec()),
            int'(pack(m_t / 3600, (m_t / 60) % 60, m_t % 60, m_st, m_tick, m_wrap)));
    endtask

    task automatic do_reset(input bit m, input bit i);
        rst = 1'b1;
        bus.mode_btn = m;
        bus.inc_btn = i;
        #1;
        chk("rst_async", int'(dut_vec()), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic press(input bit is_mode, input int n);
        repeat (n) begin
            if (is_mode) bus.mode_btn = 1'b1; else bus.inc_btn = 1'b1;
            step();
            bus.mode_btn = 1'b0;
            bus.inc_btn = 1'b0;
            step();
        end
    endtask

    initial begin
        int k, wraps, min_changes, tick_no, tick_at_min, exp_s;
        bit bad;

        tbl[0] = '{0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 0, 1};
        tbl[2] = '{0, 1, 1, 0, 0, 1};
        tbl[3] = '{0, 0, 1, 0, 0, 1};
        tbl[4] = '{1, 1, 1, 0, 0, 2};
        tbl[5] = '{0, 1, 1, 0, 0, 2};
        tbl[6] = '{0, 0, 1, 0, 0, 2};
        tbl[7] = '{0, 1, 1, 1, 0, 2};
        tbl[8] = '{1, 0, 1, 1, 0, 0};

        bus.mode_btn = 1'b0;
        bus.inc_btn = 1'b0;
        model_reset();
        #2;

        // Buttons held high through reset release are not presses; first tick after 4 clocks.
        do_reset(1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("held_field", int'(bus.set_field), 0);
            chk("first_tick", int'(bus.sec_tick), (i == 4) ? 1 : 0);
        end

        // Vector table: set flow with simultaneous MODE+INC and held INC.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            bus.mode_btn = tbl[i].mode;
            bus.inc_btn = tbl[i].inc;
            step();
            chk("tbl_hms", int'({bus.hours, bus.minutes, bus.seconds}),
                int'({5'(tbl[i].hh), 6'(tbl[i].mm), 6'(tbl[i].ss)}));
            chk("tbl_field", int'(bus.set_field), tbl[i].field);
        end

        // Long set flow wraps hours and minutes; tick 4 clocks after final MODE.
        do_reset(1'b0, 1'b0);
        step();
        press(1'b1, 1);
        press(1'b0, 25);
        press(1'b1, 1);
        press(1'b0, 61);
        press(1'b1, 1);
        chk("setflow_hms", int'({bus.hours, bus.minutes, bus.seconds, bus.set_field}),
            int'({5'd1, 6'd1, 6'd0, 2'd0}));
        k = 1;
        while (!bus.sec_tick && k < 10) begin
            step();
            k++;
        end
        chk("setflow_tick_lat", k, 4);

        // Preload 23:59 and run into the day wrap.
        press(1'b1, 1);
        press(1'b0, 22);
        press(1'b1, 1);
        press(1'b0, 58);
        press(1'b1, 1);
        chk("preload", int'({bus.hours, bus.minutes, bus.seconds}), int'({5'd23, 6'd59, 6'd0}));
        k = 0;
        while (!(m_tick && m_t % 60 == 58) && k < 300) begin
            step();
            k++;
        end
        chk("reach_58_bound", (k < 300) ? 1 : 0, 1);
        wraps = 0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.day_wrap) begin
                wraps++;
                if (!bus.sec_tick || bus.hours != 0 || bus.minutes != 0 || bus.seconds != 0) bad = 1'b1;
            end
        end
        chk("wrap_count", wraps, 1);
        chk("wrap_coincident", int'(bad), 0);
        chk("wrap_final", int'({bus.hours, bus.minutes, bus.seconds}), 0);

        // Minute carry on the 60th tick.
        min_changes = 0;
        tick_no = 0;
        tick_at_min = -1;
        for (int i = 0; i < 240; i++) begin
            step();
            if (bus.sec_tick) tick_no++;
            if (bus.minutes == 1 && tick_at_min < 0) begin
                min_changes++;
                tick_at_min = tick_no;
            end
        end
        chk("carry_changes", min_changes, 1);
        chk("carry_tick_no", tick_at_min, 60);
        chk("carry_final", int'({bus.hours, bus.minutes, bus.seconds}), int'({5'd0, 6'd1, 6'd0}));

        // MODE press on a tick cycle: tick applied and SET_HR entered.
        k = 0;
        while (m_ph != HZ - 1 && k < 10) begin
            step();
            k++;
        end
        exp_s = (m_t % 60 + 1) % 60;
        bus.mode_btn = 1'b1;
        step();
        bus.mode_btn = 1'b0;
        chk("mode_tick_sec", int'(bus.seconds), exp_s);
        chk("mode_tick_field", int'(bus.set_field), 1);
        step();
        press(1'b1, 2);

        // Reset while setting minutes.
        do_reset(1'b0, 1'b0);
        step();
        press(1'b1, 2);
        press(1'b0, 37);
        chk("pre_rst_min", int'({bus.minutes, bus.set_field}), int'({6'd37, 2'd2}));
        do_reset(1'b0, 1'b0);
        k = 0;
        while (!bus.sec_tick && k < 10) begin
            step();
            k++;
        end
        chk("post_rst_tick", k, 4);
        chk("post_rst_field", int'(bus.set_field), 0);

        // Random button activity against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.mode_btn = ($urandom_range(0, 19) == 0);
            bus.inc_btn = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
